// File: rtl/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- traceback memory controller and scheduler
//
// Purpose:
//   Buffers the 8-bit survivor decision vectors coming from the ACS array into
//   four round-robin banks of DEPTH entries each. While one bank is being
//   written, the two previously completed banks are streamed back in reverse
//   address order to the traceback unit. Bank rd0 (one behind the write bank)
//   feeds the traceback input; bank rd1 (two behind) feeds the decode input.
//   The traceback/decode phase toggles once per block period.
//
// Parameters:
//   DEPTH  entries per bank (traceback block length), power of 2, >= 2
//   AW     bank address width, derived from DEPTH
//
// Ports:
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   dec_valid     in   1  decision vector valid; controller advances only then
//   dec_in        in   8  survivor decision vector, one bit per trellis state
//   tb_enable     out  1  traceback unit enable (two or more blocks buffered)
//   tb_selection  out  1  phase to traceback unit: 0 = traceback, 1 = decode
//   tb_d_in_0     out  8  decision vector read from the traceback bank
//   tb_d_in_1     out  8  decision vector read from the decode bank
//   tb_valid      out  1  tb_* outputs were updated this cycle
//   block_done    out  1  one-cycle pulse after the last entry of a bank lands
//
// Optional feature (macro TBC_PERF_EN):
//   blk_cnt       out 16  block wraps since reset, wraps modulo 2^16
//   stall_cnt     out 16  dec_valid=0 cycles after leaving EMPTY, saturating
// -----------------------------------------------------------------------------
module tb_mem_ctrl #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [7:0] dec_in,
  output logic       tb_enable,
  output logic       tb_selection,
  output logic [7:0] tb_d_in_0,
  output logic [7:0] tb_d_in_1,
  output logic       tb_valid,
  output logic       block_done
`ifdef TBC_PERF_EN
  ,
  output logic [15:0] blk_cnt,
  output logic [15:0] stall_cnt
`endif
);

  // Fill state: the encoding doubles as the saturating count of completed
  // blocks, so EMPTY..RUN correspond to fill = 0..3.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PRIME = 2'd1,
    S_TRACE = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_wa;
  logic [AW-1:0]   w_ra;
  logic [1:0]      r_wb;
  logic [1:0]      w_rd0;
  logic [1:0]      w_rd1;
  logic            r_phase;
  logic            w_wrap;

  // Decoded per-state output qualifiers.
  logic            w_en;
  logic            w_pass_d0;
  logic            w_pass_d1;

  logic [7:0]      r_bank [4][DEPTH];

  logic            r_enable;
  logic            r_selection;
  logic [7:0]      r_d_in_0;
  logic [7:0]      r_d_in_1;
  logic            r_valid;
  logic            r_block_done;

  // ---------------------------------------------------------------------------
  // Address and bank arithmetic
  // ---------------------------------------------------------------------------
  // DEPTH is a power of 2, so DEPTH-1-wa is simply the bitwise inverse of wa.
  assign w_ra   = ~r_wa;
  // Read banks trail the write bank; 2-bit arithmetic gives the mod-4 wrap.
  assign w_rd0  = r_wb - 2'd1;
  assign w_rd1  = r_wb - 2'd2;
  // Last entry of the current bank accepted this cycle.
  assign w_wrap = dec_valid & (&r_wa);

  // ---------------------------------------------------------------------------
  // Fill FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_en        = 1'b0;
    w_pass_d0   = 1'b0;
    w_pass_d1   = 1'b0;

    case (r_state)
      S_EMPTY: begin
        if (w_wrap) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (w_wrap) w_state_nxt = S_TRACE;
      end
      S_TRACE: begin
        // Bank rd0 holds a full block; rd1 still holds pre-start garbage.
        w_en      = 1'b1;
        w_pass_d0 = 1'b1;
        if (w_wrap) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Terminal: both read banks hold real data from here on.
        w_en      = 1'b1;
        w_pass_d0 = 1'b1;
        w_pass_d1 = 1'b1;
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write address, write bank and phase
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wa    <= '0;
      r_wb    <= 2'd0;
      r_phase <= 1'b0;
    end else if (dec_valid) begin
      // Power-of-2 depth: the increment wraps DEPTH-1 -> 0 by itself.
      r_wa <= r_wa + 1'b1;
      if (w_wrap) begin
        r_wb    <= r_wb + 2'd1;
        r_phase <= ~r_phase;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage
  // ---------------------------------------------------------------------------
  // NOTE: the bank array is deliberately left out of reset; startup masking
  // hides stale contents, and a reset-free array maps onto RAM primitives.
  // Reset still blocks the write so a beat coincident with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && dec_valid) begin
      r_bank[r_wb][r_wa] <= dec_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered reads and output stage
  // ---------------------------------------------------------------------------
  // The read port register is also the output register. Masking uses the fill
  // state in force at the accepted beat, so the masked value and the data it
  // replaces line up exactly. The read at ra can never hit the bank being
  // written because rd0/rd1 always differ from wb.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable     <= 1'b0;
      r_selection  <= 1'b0;
      r_d_in_0     <= 8'h00;
      r_d_in_1     <= 8'h00;
      r_valid      <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_valid      <= dec_valid;
      r_block_done <= w_wrap;
      if (dec_valid) begin
        r_enable    <= w_en;
        r_selection <= r_phase;
        r_d_in_0    <= w_pass_d0 ? r_bank[w_rd0][w_ra] : 8'h00;
        r_d_in_1    <= w_pass_d1 ? r_bank[w_rd1][w_ra] : 8'h00;
      end
    end
  end

  assign tb_enable    = r_enable;
  assign tb_selection = r_selection;
  assign tb_d_in_0    = r_d_in_0;
  assign tb_d_in_1    = r_d_in_1;
  assign tb_valid     = r_valid;
  assign block_done   = r_block_done;

`ifdef TBC_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [15:0] r_blk_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt   <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_wrap) begin
        r_blk_cnt <= r_blk_cnt + 16'd1;
      end
      // Idle cycles before the first block completes are not stalls.
      if (!dec_valid && (r_state != S_EMPTY) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign blk_cnt   = r_blk_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tb_mem_ctrl -- self-checking bench for tb_mem_ctrl (DEPTH = 16)
//
// Each accepted beat pushes the expected output record onto a scoreboard
// queue; the record is popped and compared when the DUT raises tb_valid.
// Stall cycles check that the outputs hold. Block-pattern data
// ({block idx, beat idx}) is additionally checked against closed-form values.
// -----------------------------------------------------------------------------
module tb_tb_mem_ctrl;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [7:0] dec_in;
  logic       tb_enable;
  logic       tb_selection;
  logic [7:0] tb_d_in_0;
  logic [7:0] tb_d_in_1;
  logic       tb_valid;
  logic       block_done;
`ifdef TBC_PERF_EN
  logic [15:0] blk_cnt;
  logic [15:0] stall_cnt;
`endif

  tb_mem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_in       (dec_in),
    .tb_enable    (tb_enable),
    .tb_selection (tb_selection),
    .tb_d_in_0    (tb_d_in_0),
    .tb_d_in_1    (tb_d_in_1),
    .tb_valid     (tb_valid),
    .block_done   (block_done)
`ifdef TBC_PERF_EN
    ,
    .blk_cnt      (blk_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sel;
    logic       en;
    logic       done;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0]  m_mem [4][DEPTH];
  logic [3:0]  m_wa;
  logic [1:0]  m_wb;
  logic [1:0]  m_fill;
  logic        m_phase;
  int          m_blk;
  int          m_stall;

  // Last values the DUT should be holding through a stall
  logic [7:0]  last_d0;
  logic [7:0]  last_d1;
  logic        last_sel;
  logic        last_en;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wa     = 4'd0;
    m_wb     = 2'd0;
    m_fill   = 2'd0;
    m_phase  = 1'b0;
    m_blk    = 0;
    m_stall  = 0;
    last_d0  = 8'h00;
    last_d1  = 8'h00;
    last_sel = 1'b0;
    last_en  = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: drive at the falling edge, compare 1 time unit after the
  // rising edge.
  task automatic step(input logic v, input logic [7:0] d);
    exp_t       e;
    logic [3:0] ra;
    logic [1:0] rd0;
    logic [1:0] rd1;
    @(negedge clk);
    rst       = 1'b0;
    dec_valid = v;
    dec_in    = d;
    if (v) begin
      ra     = 4'd15 - m_wa;
      rd0    = m_wb - 2'd1;
      rd1    = m_wb - 2'd2;
      e.d0   = (m_fill >= 2'd2) ? m_mem[rd0][ra] : 8'h00;
      e.d1   = (m_fill == 2'd3) ? m_mem[rd1][ra] : 8'h00;
      e.sel  = m_phase;
      e.en   = (m_fill >= 2'd2);
      e.done = (m_wa == 4'd15);
      sb_q.push_back(e);
      m_mem[m_wb][m_wa] = d;
      if (m_wa == 4'd15) begin
        m_wb    = m_wb + 2'd1;
        m_phase = ~m_phase;
        m_blk++;
        if (m_fill != 2'd3) m_fill = m_fill + 2'd1;
      end
      m_wa = m_wa + 4'd1;
    end else if (m_fill != 2'd0) begin
      m_stall++;
    end
    @(posedge clk);
    #1;
    check("tb_valid", {15'd0, tb_valid}, {15'd0, v});
    if (tb_valid) begin
      check("sb_depth", 16'(sb_q.size()), 16'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("tb_d_in_0", {8'd0, tb_d_in_0}, {8'd0, e.d0});
        check("tb_d_in_1", {8'd0, tb_d_in_1}, {8'd0, e.d1});
        check("tb_selection", {15'd0, tb_selection}, {15'd0, e.sel});
        check("tb_enable", {15'd0, tb_enable}, {15'd0, e.en});
        check("block_done", {15'd0, block_done}, {15'd0, e.done});
        last_d0  = e.d0;
        last_d1  = e.d1;
        last_sel = e.sel;
        last_en  = e.en;
      end
    end else begin
      check("hold_d_in_0", {8'd0, tb_d_in_0}, {8'd0, last_d0});
      check("hold_d_in_1", {8'd0, tb_d_in_1}, {8'd0, last_d1});
      check("hold_selection", {15'd0, tb_selection}, {15'd0, last_sel});
      check("hold_enable", {15'd0, tb_enable}, {15'd0, last_en});
      check("stall_block_done", {15'd0, block_done}, 16'd0);
    end
  endtask

  // Synchronous reset, optionally with dec_valid high to show rst wins.
  task automatic do_reset(input logic v);
    @(negedge clk);
    rst       = 1'b1;
    dec_valid = v;
    dec_in    = 8'hFF;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_valid", {15'd0, tb_valid}, 16'd0);
    check("rst_enable", {15'd0, tb_enable}, 16'd0);
    check("rst_selection", {15'd0, tb_selection}, 16'd0);
    check("rst_d_in_0", {8'd0, tb_d_in_0}, 16'd0);
    check("rst_d_in_1", {8'd0, tb_d_in_1}, 16'd0);
    check("rst_block_done", {15'd0, block_done}, 16'd0);
`ifdef TBC_PERF_EN
    check("rst_blk_cnt", blk_cnt, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
  endtask

  // One block of 16 accepted beats. Block b (counted from the last reset)
  // carries {b, beat} unless a5 is set. For b >= 2 the traceback read returns
  // block b-1 reversed, and for b >= 3 the decode read returns block b-2.
  task automatic run_block(input int b, input bit a5, input int stall_at, input int n_stall);
    logic [7:0] d;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < n_stall; s++) step(1'b0, 8'h3C);
      end
      d = a5 ? 8'hA5 : {4'(b), 4'(k)};
      step(1'b1, d);
      if (b >= 2) check("pattern_d0", {8'd0, tb_d_in_0}, {8'd0, 4'(b - 1), 4'(15 - k)});
      if (b >= 3) check("pattern_d1", {8'd0, tb_d_in_1}, {8'd0, 4'(b - 2), 4'(15 - k)});
      if (b == 2) check("pattern_d1_masked", {8'd0, tb_d_in_1}, 16'd0);
      if (b < 2) check("pattern_en_low", {15'd0, tb_enable}, 16'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    dec_valid = 1'b0;
    dec_in    = 8'h00;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < DEPTH; k++) m_mem[i][k] = 8'h00;
    end

    do_reset(1'b0);

    // First block of constant data, then patterned blocks up to eight total,
    // with a five-cycle stall at wa=7 in block 5.
    run_block(0, 1'b1, -1, 0);
    for (int b = 1; b < 8; b++) begin
      run_block(b, 1'b0, (b == 5) ? 7 : -1, 5);
    end

    // Mid-block reset at wa=9 with a coincident valid beat.
    for (int k = 0; k < 9; k++) step(1'b1, 8'h5A);
    do_reset(1'b1);

    // Enable must stay low through two fresh blocks, then rise in the third.
    run_block(0, 1'b0, -1, 0);
    run_block(1, 1'b0, -1, 0);
    run_block(2, 1'b0, -1, 0);
    check("en_after_refill", {15'd0, tb_enable}, 16'd1);

    // Five blocks with three stall cycles after leaving EMPTY.
    do_reset(1'b0);
    for (int b = 0; b < 5; b++) begin
      run_block(b, 1'b0, (b == 2) ? 4 : -1, 3);
    end
    step(1'b0, 8'h00);
    check("idle_valid_low", {15'd0, tb_valid}, 16'd0);
`ifdef TBC_PERF_EN
    check("blk_cnt", blk_cnt, 16'(m_blk));
    check("stall_cnt", stall_cnt, 16'(m_stall));
    check("blk_cnt_5", blk_cnt, 16'd5);
    check("stall_cnt_4", stall_cnt, 16'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
